// File: rtl/mux4_rr_arbiter_pkg.sv
// Shared definitions for the 4-way round-robin mux arbiter: FSM encoding,
// default parameters and a small one-hot helper.
package mux4_rr_arbiter_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  localparam int DEFAULT_MAX_HOLD = 8;
  localparam int DEFAULT_CW       = 8;

  // Index -> one-hot grant vector.
  function automatic logic [3:0] onehot4(input logic [1:0] idx);
    logic [3:0] v;
    v      = 4'b0000;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/mux4_rr_arbiter_if.sv
// Request/grant bundle between four requesters and the arbiter.
//
// Handshake: req[i] is a level request held high for as long as requester i
// wants the resource. gnt[i] is the registered acceptance. A transfer owns the
// resource on every cycle where gnt[i] is high. Dropping req[i] releases it at
// the next edge. {S1,S0} drives the mux select and holds its last value while
// idle. dbg_state and dbg_cnt expose the FSM state and the hold counter.
interface mux4_rr_arbiter_if
  import mux4_rr_arbiter_pkg::*;
#(
  parameter int CW = DEFAULT_CW
) ();

  logic [3:0]    req;
  logic [3:0]    gnt;
  logic          S1;
  logic          S0;
  logic          busy;
  logic          preempt;
  state_e        dbg_state;
  logic [CW-1:0] dbg_cnt;

  // Requester side.
  modport master (
    output req,
    input  gnt, S1, S0, busy, preempt, dbg_state, dbg_cnt
  );

  // Arbiter side.
  modport slave (
    input  req,
    output gnt, S1, S0, busy, preempt, dbg_state, dbg_cnt
  );

endinterface

// File: rtl/mux4_rr_arbiter_rr_pick4.sv
// Combinational round-robin picker: the first set request bit found while
// scanning last+1, last+2, ... modulo 4. Reusable by other 4-way arbiters.
module rr_pick4 (
  input  logic [3:0] req,
  input  logic [1:0] last,
  output logic [1:0] winner,
  output logic       valid
);

  logic [1:0] idx;

  // Rotating priority scan starting just after the previous winner.
  always_comb begin
    winner = 2'd0;
    valid  = 1'b0;
    idx    = 2'd0;
    for (int k = 1; k <= 4; k++) begin
      idx = last + 2'(k);
      if (!valid && req[idx]) begin
        winner = idx;
        valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter for a shared 4:1 mux path. Registers a one-hot grant,
// drives the mux select directly and revokes a grant once it has been held
// MAX_HOLD cycles while another requester is waiting.
module mux4_rr_arbiter
  import mux4_rr_arbiter_pkg::*;
#(
  parameter int MAX_HOLD = DEFAULT_MAX_HOLD,
  parameter int CW       = DEFAULT_CW
) (
  input  logic              clk,
  input  logic              reset,
  mux4_rr_arbiter_if.slave  bus
);

  localparam logic [CW-1:0] MAX_HOLD_C = CW'(MAX_HOLD);

  state_e        state_q, state_d;
  logic [3:0]    gnt_q, gnt_d;
  logic [1:0]    sel_q, sel_d;
  logic          busy_q, busy_d;
  logic          preempt_q, preempt_d;
  logic [1:0]    last_q, last_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [1:0]    winner;
  logic          winner_valid;
  logic          others_waiting;

  rr_pick4 u_pick (
    .req    (bus.req),
    .last   (last_q),
    .winner (winner),
    .valid  (winner_valid)
  );

  // Another requester is waiting if any request bit outside the holder is set.
  assign others_waiting = |(bus.req & ~gnt_q);

  // Next-state and next-output logic for the IDLE/GRANT FSM.
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    sel_d     = sel_q;
    busy_d    = busy_q;
    preempt_d = 1'b0;
    last_d    = last_q;
    cnt_d     = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (winner_valid) begin
          state_d = GRANT;
          gnt_d   = onehot4(winner);
          sel_d   = winner;
          busy_d  = 1'b1;
          cnt_d   = CW'(1);
          last_d  = winner;
        end
      end
      GRANT: begin
        // Release wins over timeout; select keeps the last index either way.
        if (!bus.req[sel_q]) begin
          state_d = IDLE;
          gnt_d   = 4'b0000;
          busy_d  = 1'b0;
          cnt_d   = '0;
        end else if ((cnt_q >= MAX_HOLD_C) && others_waiting) begin
          state_d   = IDLE;
          gnt_d     = 4'b0000;
          busy_d    = 1'b0;
          preempt_d = 1'b1;
          cnt_d     = '0;
        end else if (cnt_q < MAX_HOLD_C) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      gnt_q     <= 4'b0000;
      sel_q     <= 2'd0;
      busy_q    <= 1'b0;
      preempt_q <= 1'b0;
      last_q    <= 2'd3;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      sel_q     <= sel_d;
      busy_q    <= busy_d;
      preempt_q <= preempt_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.S1        = sel_q[1];
  assign bus.S0        = sel_q[0];
  assign bus.busy      = busy_q;
  assign bus.preempt   = preempt_q;
  assign bus.dbg_state = state_q;
  assign bus.dbg_cnt   = cnt_q;

  // Structural invariants of the grant outputs.
  a_gnt_onehot0 : assert property (@(posedge clk) $onehot0(gnt_q));
  a_busy_gnt    : assert property (@(posedge clk) busy_q == (|gnt_q));
  a_sel_match   : assert property (@(posedge clk) busy_q |-> gnt_q[sel_q]);
  a_preempt_1c  : assert property (@(posedge clk) disable iff (reset)
                                   preempt_q |=> !preempt_q);

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Self-checking bench for mux4_rr_arbiter (MAX_HOLD=8, CW=8). Each task drives
// req, pushes the expected response for the next edge and compares it after
// the edge. Word layout: {gnt, S1, S0, busy, preempt, state, cnt}.
module tb_mux4_rr_arbiter;
  import mux4_rr_arbiter_pkg::*;

  localparam int W = 17;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_err;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] obs;
  logic [W-1:0] exp_w;

  mux4_rr_arbiter_if #(.CW(8)) bus ();

  mux4_rr_arbiter #(.MAX_HOLD(8), .CW(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Clock and watchdog.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got running want finished");
    $fatal(1);
  end

  function automatic logic [W-1:0] pk(input logic [3:0] g, input logic [1:0] s,
                                      input logic b, input logic p,
                                      input logic st, input logic [7:0] c);
    return {g, s, b, p, st, c};
  endfunction

  function automatic logic [3:0] oh(input int i);
    logic [3:0] v;
    v = 4'b0001 << i;
    return v;
  endfunction

  // Driver tasks.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    bus.req = 4'b0000;
    tick();
    reset   = 1'b0;
  endtask

  task automatic test_reset();
    reset   = 1'b1;
    bus.req = 4'b1111;
    for (int c = 0; c < 2; c++) begin
      exp_q.push_back(pk(4'b0000, 2'd0, 1'b0, 1'b0, IDLE, 8'd0));
      tick();
      obs = {bus.gnt, bus.S1, bus.S0, bus.busy, bus.preempt, bus.dbg_state, bus.dbg_cnt};
      exp_w = exp_q.pop_front(); n_cmp++;
      if (obs !== exp_w) begin n_err++; $display("FAIL reset c%0d: got %h want %h", c, obs, exp_w); end
    end
    reset   = 1'b0;
    bus.req = 4'b0000;
    exp_q.push_back(pk(4'b0000, 2'd0, 1'b0, 1'b0, IDLE, 8'd0));
    tick();
    obs = {bus.gnt, bus.S1, bus.S0, bus.busy, bus.preempt, bus.dbg_state, bus.dbg_cnt};
    exp_w = exp_q.pop_front(); n_cmp++;
    if (obs !== exp_w) begin n_err++; $display("FAIL reset_idle: got %h want %h", obs, exp_w); end
  endtask

  task automatic test_single();
    logic [3:0] r[4];
    logic [W-1:0] e[4];
    do_reset();
    r = '{4'b0010, 4'b0010, 4'b0000, 4'b0000};
    e = '{pk(4'b0010, 2'd1, 1'b1, 1'b0, GRANT, 8'd1),
          pk(4'b0010, 2'd1, 1'b1, 1'b0, GRANT, 8'd2),
          pk(4'b0000, 2'd1, 1'b0, 1'b0, IDLE,  8'd0),
          pk(4'b0000, 2'd1, 1'b0, 1'b0, IDLE,  8'd0)};
    for (int c = 0; c < 4; c++) begin
      bus.req = r[c];
      exp_q.push_back(e[c]);
      tick();
      obs = {bus.gnt, bus.S1, bus.S0, bus.busy, bus.preempt, bus.dbg_state, bus.dbg_cnt};
      exp_w = exp_q.pop_front(); n_cmp++;
      if (obs !== exp_w) begin n_err++; $display("FAIL single c%0d: got %h want %h", c, obs, exp_w); end
    end
  endtask

  task automatic test_rotation();
    do_reset();
    for (int g = 0; g < 5; g++) begin
      for (int k = 1; k <= 9; k++) begin
        bus.req = 4'b1111;
        if (k <= 8) exp_q.push_back(pk(oh(g % 4), 2'(g % 4), 1'b1, 1'b0, GRANT, 8'(k)));
        else        exp_q.push_back(pk(4'b0000, 2'(g % 4), 1'b0, 1'b1, IDLE, 8'd0));
        tick();
        obs = {bus.gnt, bus.S1, bus.S0, bus.busy, bus.preempt, bus.dbg_state, bus.dbg_cnt};
        exp_w = exp_q.pop_front(); n_cmp++;
        if (obs !== exp_w) begin n_err++; $display("FAIL rotation g%0d k%0d: got %h want %h", g, k, obs, exp_w); end
      end
    end
  endtask

  task automatic test_saturate();
    do_reset();
    for (int c = 1; c <= 51; c++) begin
      bus.req = (c <= 50) ? 4'b0100 : 4'b0000;
      if (c <= 50) exp_q.push_back(pk(4'b0100, 2'd2, 1'b1, 1'b0, GRANT, 8'((c < 8) ? c : 8)));
      else         exp_q.push_back(pk(4'b0000, 2'd2, 1'b0, 1'b0, IDLE, 8'd0));
      tick();
      obs = {bus.gnt, bus.S1, bus.S0, bus.busy, bus.preempt, bus.dbg_state, bus.dbg_cnt};
      exp_w = exp_q.pop_front(); n_cmp++;
      if (obs !== exp_w) begin n_err++; $display("FAIL saturate c%0d: got %h want %h", c, obs, exp_w); end
    end
  endtask

  task automatic test_rotate_from_last();
    logic [3:0] r[4];
    logic [W-1:0] e[4];
    do_reset();
    r = '{4'b0010, 4'b1001, 4'b1001, 4'b0000};
    e = '{pk(4'b0010, 2'd1, 1'b1, 1'b0, GRANT, 8'd1),
          pk(4'b0000, 2'd1, 1'b0, 1'b0, IDLE,  8'd0),
          pk(4'b1000, 2'd3, 1'b1, 1'b0, GRANT, 8'd1),
          pk(4'b0000, 2'd3, 1'b0, 1'b0, IDLE,  8'd0)};
    for (int c = 0; c < 4; c++) begin
      bus.req = r[c];
      exp_q.push_back(e[c]);
      tick();
      obs = {bus.gnt, bus.S1, bus.S0, bus.busy, bus.preempt, bus.dbg_state, bus.dbg_cnt};
      exp_w = exp_q.pop_front(); n_cmp++;
      if (obs !== exp_w) begin n_err++; $display("FAIL from_last c%0d: got %h want %h", c, obs, exp_w); end
    end
  endtask

  task automatic test_release_timeout();
    do_reset();
    for (int c = 1; c <= 11; c++) begin
      if (c == 1) begin
        bus.req = 4'b0001;
        exp_q.push_back(pk(4'b0001, 2'd0, 1'b1, 1'b0, GRANT, 8'd1));
      end else if (c <= 8) begin
        bus.req = 4'b0011;
        exp_q.push_back(pk(4'b0001, 2'd0, 1'b1, 1'b0, GRANT, 8'(c)));
      end else if (c == 9) begin
        bus.req = 4'b0010;
        exp_q.push_back(pk(4'b0000, 2'd0, 1'b0, 1'b0, IDLE, 8'd0));
      end else if (c == 10) begin
        bus.req = 4'b0010;
        exp_q.push_back(pk(4'b0010, 2'd1, 1'b1, 1'b0, GRANT, 8'd1));
      end else begin
        bus.req = 4'b0000;
        exp_q.push_back(pk(4'b0000, 2'd1, 1'b0, 1'b0, IDLE, 8'd0));
      end
      tick();
      obs = {bus.gnt, bus.S1, bus.S0, bus.busy, bus.preempt, bus.dbg_state, bus.dbg_cnt};
      exp_w = exp_q.pop_front(); n_cmp++;
      if (obs !== exp_w) begin n_err++; $display("FAIL rel_timeout c%0d: got %h want %h", c, obs, exp_w); end
    end
  endtask

  task automatic test_reset_mid_grant();
    logic [3:0] r[5];
    logic       rs[5];
    logic [W-1:0] e[5];
    do_reset();
    r  = '{4'b1000, 4'b1000, 4'b1111, 4'b1111, 4'b0000};
    rs = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    e  = '{pk(4'b1000, 2'd3, 1'b1, 1'b0, GRANT, 8'd1),
           pk(4'b1000, 2'd3, 1'b1, 1'b0, GRANT, 8'd2),
           pk(4'b0000, 2'd0, 1'b0, 1'b0, IDLE,  8'd0),
           pk(4'b0001, 2'd0, 1'b1, 1'b0, GRANT, 8'd1),
           pk(4'b0000, 2'd0, 1'b0, 1'b0, IDLE,  8'd0)};
    for (int c = 0; c < 5; c++) begin
      bus.req = r[c];
      reset   = rs[c];
      exp_q.push_back(e[c]);
      tick();
      obs = {bus.gnt, bus.S1, bus.S0, bus.busy, bus.preempt, bus.dbg_state, bus.dbg_cnt};
      exp_w = exp_q.pop_front(); n_cmp++;
      if (obs !== exp_w) begin n_err++; $display("FAIL reset_mid c%0d: got %h want %h", c, obs, exp_w); end
    end
    reset = 1'b0;
  endtask

  task automatic test_back_to_back();
    int who;
    int len;
    for (int b = 0; b < 12; b++) begin
      who = $urandom_range(0, 3);
      len = $urandom_range(1, 5);
      for (int k = 1; k <= len + 1; k++) begin
        bus.req = (k <= len) ? oh(who) : 4'b0000;
        if (k <= len) exp_q.push_back(pk(oh(who), 2'(who), 1'b1, 1'b0, GRANT, 8'(k)));
        else          exp_q.push_back(pk(4'b0000, 2'(who), 1'b0, 1'b0, IDLE, 8'd0));
        tick();
        obs = {bus.gnt, bus.S1, bus.S0, bus.busy, bus.preempt, bus.dbg_state, bus.dbg_cnt};
        exp_w = exp_q.pop_front(); n_cmp++;
        if (obs !== exp_w) begin n_err++; $display("FAIL b2b b%0d k%0d: got %h want %h", b, k, obs, exp_w); end
      end
    end
  endtask

  // Test sequence and final report.
  initial begin
    n_cmp   = 0;
    n_err   = 0;
    reset   = 1'b1;
    bus.req = 4'b0000;
    test_reset();
    test_single();
    test_rotation();
    test_saturate();
    test_rotate_from_last();
    test_release_timeout();
    test_reset_mid_grant();
    test_back_to_back();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
